// File: rtl/result_logger_if.sv
// rtl/result_logger_if.sv - valid/ready output handshake of the result logger FIFO
interface result_logger_if;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );
endinterface

// File: rtl/result_logger.sv
// rtl/result_logger.sv - logs changed altitude/battery results into a FWFT FIFO with low-battery alarm
module result_logger #(
    parameter int                 DEPTH     = 4,
    parameter logic signed [15:0] BATT_LOW  = 16'sd100,
    parameter int                 ALARM_CNT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [15:0]                result_a,
    input  logic [15:0]                result_b,
    input  logic                       clear_status,
    result_logger_if.master            out_if,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow,
    output logic [7:0]                 drop_count,
    output logic                       batt_alarm
);
    localparam int               AW        = $clog2(DEPTH);
    localparam logic [AW:0]      DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [3:0]       ALARM_MAX = 4'(ALARM_CNT);

    logic [15:0]   prev_a_q, prev_a_d;
    logic [15:0]   prev_b_q, prev_b_d;
    logic [3:0]    low_cnt_q, low_cnt_d;
    logic          batt_alarm_q, batt_alarm_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_count_q, drop_count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [16:0]   mem_q [DEPTH];
    logic [16:0]   mem_d [DEPTH];

    logic          chg_a, chg_b, push, push_b, pop, full, accept, drop;
    logic [16:0]   push_data;

    // Change detection, push arbitration (A before B), FIFO update, drop and alarm accounting
    always_comb begin
        chg_a        = (result_a != prev_a_q);
        chg_b        = (result_b != prev_b_q);
        push         = chg_a || chg_b;
        push_b       = !chg_a && chg_b;
        push_data    = chg_a ? {1'b0, result_a} : {1'b1, result_b};
        pop          = (count_q != '0) && out_if.out_ready;
        full         = (count_q == DEPTH_C);
        accept       = push && (!full || pop);
        drop         = push && !accept;

        prev_a_d     = prev_a_q;
        prev_b_d     = prev_b_q;
        low_cnt_d    = low_cnt_q;
        batt_alarm_d = batt_alarm_q;
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        mem_d        = mem_q;

        // The previous value advances even on a drop so the same value is never retried
        if (chg_a) begin
            prev_a_d = result_a;
        end else if (chg_b) begin
            prev_b_d = result_b;
        end

        if (accept) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_d = drop_count_q + 8'd1;
            end
        end

        // Every battery push attempt counts toward the alarm, accepted or dropped
        if (push_b) begin
            if ($signed(result_b) < BATT_LOW) begin
                if (low_cnt_q != ALARM_MAX) begin
                    low_cnt_d = low_cnt_q + 4'd1;
                end
                if (low_cnt_d == ALARM_MAX) begin
                    batt_alarm_d = 1'b1;
                end
            end else begin
                low_cnt_d = 4'd0;
            end
        end

        // Status clear wins over same-cycle alarm/drop accounting; FIFO is untouched
        if (clear_status) begin
            low_cnt_d    = 4'd0;
            batt_alarm_d = 1'b0;
            overflow_d   = 1'b0;
            drop_count_d = 8'd0;
        end
    end

    // State register with asynchronous reset; queued entries are discarded on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_a_q     <= '0;
            prev_b_q     <= '0;
            low_cnt_q    <= '0;
            batt_alarm_q <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            prev_a_q     <= prev_a_d;
            prev_b_q     <= prev_b_d;
            low_cnt_q    <= low_cnt_d;
            batt_alarm_q <= batt_alarm_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            mem_q        <= mem_d;
        end
    end

    assign out_if.out_valid = (count_q != '0);
    assign out_if.out_data  = mem_q[rd_ptr_q];
    assign fifo_count       = count_q;
    assign overflow         = overflow_q;
    assign drop_count       = drop_count_q;
    assign batt_alarm       = batt_alarm_q;
endmodule

// File: tb/tb_result_logger.sv
// tb/tb_result_logger.sv - directed self-checking bench for result_logger
module tb_result_logger;
    logic        clk;
    logic        rst;
    logic [15:0] result_a;
    logic [15:0] result_b;
    logic        clear_status;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        batt_alarm;

    int checks;
    int failures;

    result_logger_if rl_if ();

    result_logger dut (
        .clk          (clk),
        .rst          (rst),
        .result_a     (result_a),
        .result_b     (result_b),
        .clear_status (clear_status),
        .out_if       (rl_if.master),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .drop_count   (drop_count),
        .batt_alarm   (batt_alarm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        result_a     = 16'h0000;
        result_b     = 16'h0000;
        clear_status = 1'b0;
        rl_if.out_ready = 1'b1;
        step();
        step();

        // 1: reset values, single altitude push, held input
        chk("rst_valid", 32'(rl_if.out_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_data", 32'(rl_if.out_data), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        chk("rst_alarm", 32'(batt_alarm), 32'd0);
        rst = 1'b0;
        step();
        chk("zero_not_logged", 32'(rl_if.out_valid), 32'd0);
        result_a = 16'h0010;
        step();
        chk("t1_valid", 32'(rl_if.out_valid), 32'd1);
        chk("t1_data", 32'(rl_if.out_data), 32'h00010);
        step();
        chk("t1_one_cycle", 32'(rl_if.out_valid), 32'd0);
        step();
        chk("t1_held", 32'(rl_if.out_valid), 32'd0);

        // 2: simultaneous change, A first then B
        result_a = 16'h0020;
        result_b = 16'h0050;
        step();
        chk("t2_first", 32'(rl_if.out_data), 32'h00020);
        step();
        chk("t2_second_valid", 32'(rl_if.out_valid), 32'd1);
        chk("t2_second", 32'(rl_if.out_data), 32'h10050);
        step();
        chk("t2_empty", 32'(rl_if.out_valid), 32'd0);

        // 3: overflow with DEPTH=4, then drain in order
        rl_if.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            result_a = 16'h0101 + 16'(i);
            step();
        end
        chk("t3_count", 32'(fifo_count), 32'd4);
        chk("t3_ovf", 32'(overflow), 32'd1);
        chk("t3_drop", 32'(drop_count), 32'd2);
        rl_if.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t3_drain", 32'(rl_if.out_data), 32'h00101 + 32'(i));
            step();
        end
        chk("t3_drained", 32'(rl_if.out_valid), 32'd0);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        chk("t3_clr_ovf", 32'(overflow), 32'd0);
        chk("t3_clr_drop", 32'(drop_count), 32'd0);

        // 4: three consecutive low battery values set the alarm
        result_b = 16'd50;
        step();
        chk("t4_b50", 32'(batt_alarm), 32'd0);
        result_b = 16'd60;
        step();
        chk("t4_b60", 32'(batt_alarm), 32'd0);
        result_b = 16'd70;
        step();
        chk("t4_b70_alarm", 32'(batt_alarm), 32'd1);
        chk("t4_b70_data", 32'(rl_if.out_data), 32'h10046);
        result_b = 16'd200;
        step();
        chk("t4_sticky", 32'(batt_alarm), 32'd1);
        clear_status = 1'b1;
        step();
        clear_status = 1'b0;
        chk("t4_clear", 32'(batt_alarm), 32'd0);

        // 5: a non-low value restarts the low count
        result_b = 16'd50;
        step();
        result_b = 16'd60;
        step();
        result_b = 16'd150;
        step();
        result_b = 16'd40;
        step();
        chk("t5_no_alarm", 32'(batt_alarm), 32'd0);
        result_b = 16'd30;
        step();
        chk("t5_two_low", 32'(batt_alarm), 32'd0);
        result_b = 16'd20;
        step();
        chk("t5_three_low", 32'(batt_alarm), 32'd1);

        // 6: asynchronous reset with entries queued
        step();
        step();
        rl_if.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            result_a = 16'h0201 + 16'(i);
            step();
        end
        chk("t6_count3", 32'(fifo_count), 32'd3);
        #2;
        rst      = 1'b1;
        result_a = 16'h0010;
        result_b = 16'h0000;
        #1;
        chk("t6_rst_valid", 32'(rl_if.out_valid), 32'd0);
        chk("t6_rst_count", 32'(fifo_count), 32'd0);
        chk("t6_rst_alarm", 32'(batt_alarm), 32'd0);
        step();
        rst = 1'b0;
        rl_if.out_ready = 1'b1;
        step();
        chk("t6_relog_valid", 32'(rl_if.out_valid), 32'd1);
        chk("t6_relog_data", 32'(rl_if.out_data), 32'h00010);
        chk("t6_relog_count", 32'(fifo_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
